// File: rtl/text_buffer.sv
// 4x32 character buffer between the calculator core and the text display.
// Optional cursor blink overlay is enabled with macro TEXT_BUFFER_CURSOR_BLINK_EN.
module text_buffer #(
    parameter int         BLINK_DIV   = 12500000,
    parameter logic [6:0] CURSOR_CHAR = 7'h5F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic [6:0] wr_char,
    output logic       wr_ready,
    input  logic [6:0] rd_addr,
    output logic [6:0] rd_char,
    output logic       busy
);

    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCROLL
    } state_t;

    logic [6:0] r_mem [128];
    state_t     r_state;
    logic [6:0] r_step;
    logic [1:0] r_cur_row;
    logic [4:0] r_cur_col;
    logic [6:0] r_rd_char;
    logic       r_rdy;

    state_t     w_state_nx;
    logic [6:0] w_step_nx;
    logic [1:0] w_row_nx;
    logic [4:0] w_col_nx;
    logic       w_we;
    logic [6:0] w_waddr;
    logic [6:0] w_wdata;
    logic       w_adv;
    logic       w_accept;
    logic [6:0] w_cur_addr;
    logic [6:0] w_rd_next;

    assign busy       = (r_state != ST_IDLE);
    assign wr_ready   = r_rdy & ~busy;
    assign rd_char    = r_rd_char;
    assign w_accept   = wr_valid & wr_ready;
    assign w_cur_addr = {r_cur_row, r_cur_col};

    // NOTE: every variable is given a default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        w_row_nx   = r_cur_row;
        w_col_nx   = r_cur_col;
        w_we       = 1'b0;
        w_waddr    = r_step;
        w_wdata    = SPACE;
        w_adv      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (wr_char >= 7'h20 && wr_char <= 7'h7E) begin
                        w_we    = 1'b1;
                        w_waddr = w_cur_addr;
                        w_wdata = wr_char;
                        if (r_cur_col == 5'd31) begin
                            w_col_nx = 5'd0;
                            w_adv    = 1'b1;
                        end else begin
                            w_col_nx = r_cur_col + 5'd1;
                        end
                    end else if (wr_char == 7'h0D) begin
                        w_col_nx = 5'd0;
                        w_adv    = 1'b1;
                    end else if (wr_char == 7'h08) begin
                        if (r_cur_col != 5'd0) begin
                            w_col_nx = r_cur_col - 5'd1;
                            w_we     = 1'b1;
                            w_waddr  = {r_cur_row, r_cur_col - 5'd1};
                        end else if (r_cur_row != 2'd0) begin
                            w_row_nx = r_cur_row - 2'd1;
                            w_col_nx = 5'd31;
                            w_we     = 1'b1;
                            w_waddr  = {r_cur_row - 2'd1, 5'd31};
                        end
                    end else if (wr_char == 7'h0C) begin
                        w_row_nx   = 2'd0;
                        w_col_nx   = 5'd0;
                        w_state_nx = ST_CLEAR;
                        w_step_nx  = 7'd0;
                    end
                end
            end
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_step_nx = r_step + 7'd1;
                if (r_step == 7'd127) w_state_nx = ST_IDLE;
            end
            ST_SCROLL: begin
                w_we      = 1'b1;
                w_wdata   = (r_step < 7'd96) ? r_mem[r_step + 7'd32] : SPACE;
                w_step_nx = r_step + 7'd1;
                if (r_step == 7'd127) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // A row advance off the bottom line keeps the cursor on row 3 and scrolls.
        if (w_adv) begin
            if (r_cur_row != 2'd3) begin
                w_row_nx = r_cur_row + 2'd1;
            end else begin
                w_col_nx   = 5'd0;
                w_state_nx = ST_SCROLL;
                w_step_nx  = 7'd0;
            end
        end
    end

    // NOTE: the cell array sits in flops with an async reset because reset must blank every cell at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) r_mem[i] <= SPACE;
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_step    <= 7'd0;
            r_cur_row <= 2'd0;
            r_cur_col <= 5'd0;
            r_rd_char <= SPACE;
            r_rdy     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_step    <= w_step_nx;
            r_cur_row <= w_row_nx;
            r_cur_col <= w_col_nx;
            r_rd_char <= w_rd_next;
            r_rdy     <= 1'b1;
        end
    end

`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_rd_next = (r_blink && r_state == ST_IDLE && rd_addr == w_cur_addr)
                       ? CURSOR_CHAR : r_mem[rd_addr];
`else
    localparam int         UNUSED_BLINK_DIV   = BLINK_DIV;
    localparam logic [6:0] UNUSED_CURSOR_CHAR = CURSOR_CHAR;

    assign w_rd_next = r_mem[rd_addr];
`endif

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: randomized writes against a cell/cursor model,
// read expectations queued by the stimulus and compared by a separate monitor.
module tb_text_buffer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_char  = 7'h00;
    logic [6:0] rd_addr  = 7'h00;
    logic       wr_ready;
    logic [6:0] rd_char;
    logic       busy;

    always #5 clk = ~clk;

    text_buffer #(.BLINK_DIV(4), .CURSOR_CHAR(7'h5F)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_char  (wr_char),
        .wr_ready (wr_ready),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char),
        .busy     (busy)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [6:0] m_mem [128];
    int         m_row, m_col;

    logic [6:0] exp_q  [$];
    int         addr_q [$];
    logic       rd_req = 1'b0;
    logic [6:0] mon_exp;
    int         mon_addr;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 7'h20;
        m_row = 0;
        m_col = 0;
    endfunction

    function automatic void m_adv();
        if (m_row < 3) begin
            m_row++;
        end else begin
            for (int i = 0; i < 96; i++) m_mem[i] = m_mem[i + 32];
            for (int i = 96; i < 128; i++) m_mem[i] = 7'h20;
            m_col = 0;
        end
    endfunction

    function automatic void m_accept(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            m_mem[m_row * 32 + m_col] = c;
            if (m_col == 31) begin
                m_col = 0;
                m_adv();
            end else begin
                m_col++;
            end
        end else if (c == 7'h0D) begin
            m_col = 0;
            m_adv();
        end else if (c == 7'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row * 32 + m_col] = 7'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = 31;
                m_mem[m_row * 32 + 31] = 7'h20;
            end
        end else if (c == 7'h0C) begin
            m_reset();
        end
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL rd_queue: read seen with no expectation queued, got %h", rd_char);
                end else begin
                    mon_exp  = exp_q.pop_front();
                    mon_addr = addr_q.pop_front();
                    check($sformatf("rd_char[%0d]", mon_addr), rd_char, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus tasks (all start and end at a negedge) ----------------
    task automatic rd(input int a);
        rd_addr = 7'(a);
        rd_req  = 1'b1;
        exp_q.push_back(m_mem[a]);
        addr_q.push_back(a);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic dump(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) rd(i);
    endtask

    task automatic wr_w(input logic [6:0] c, output int waited);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_char  = c;
        while (!wr_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (!wr_ready) begin
            tot_cnt++;
            $display("FAIL wr_accept: char %h not accepted after %0d cycles", c, n);
            wr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_accept(c);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wr(input logic [6:0] c);
        int w;
        wr_w(c, w);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("reset_busy", 7'(busy), 7'h00);
        check("reset_wr_ready", 7'(wr_ready), 7'h00);
        check("reset_rd_char", rd_char, 7'h20);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        @(negedge clk);
        check("wr_ready_after_release", 7'(wr_ready), 7'h01);
    endtask

    function automatic logic [6:0] rand_code();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return 7'($urandom_range(32, 126));
        if (r < 80) return 7'h0D;
        if (r < 90) return 7'h08;
        if (r < 93) return 7'h0C;
        if (r < 96) return 7'h7F;
        return 7'($urandom_range(1, 7));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int nc, ns;
        m_reset();
        @(negedge clk);
        do_reset();

        // Two printable writes, readback, cursor lands at (0,2).
        wr(7'h41);
        wr(7'h31);
        rd(0);
        rd(1);
        rd(2);
`ifdef TEXT_BUFFER_CURSOR_BLINK_EN
        rd_addr = 7'd2;
        nc = 0;
        ns = 0;
        repeat (16) begin
            @(negedge clk);
            if (rd_char == 7'h5F) nc++;
            else if (rd_char == m_mem[2]) ns++;
        end
        check("blink_cursor_phases", 7'(nc), 7'd8);
        check("blink_stored_phases", 7'(ns), 7'd8);
`else
        nc = 0;
        ns = 0;
        for (int i = 0; i < 16; i++) rd(2);
`endif
        wr(7'h23);
        rd(2);
        rd(3);

        // 33 writes wrap onto row 1; cursor ends at (1,1).
        do_reset();
        repeat (33) wr(7'h42);
        dump(0, 33);
        wr(7'h23);
        rd(33);
        rd(34);

        // Fill the screen and scroll with CR at row 3; a held write waits out the scroll.
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < ((r == 3) ? 31 : 32); c++) wr(7'h30 + 7'(r));
        wr(7'h0D);
        wr_w(7'h5A, w);
        check("scroll_wait_cycles", 7'(w), 7'd0 + 7'(128 % 128));
        check("scroll_wait_cycles_full", 7'(w >> 1), 7'd64);
        dump(0, 127);

        // Backspace at (0,0), then backspace across a row boundary.
        do_reset();
        wr(7'h58);
        wr(7'h08);
        wr(7'h08);
        dump(0, 1);
        repeat (32) wr(7'h4B);
        wr(7'h08);
        dump(0, 32);
        wr(7'h50);
        dump(30, 33);

        // Form feed clears the whole buffer.
        for (int i = 0; i < 20; i++) wr(7'h61 + 7'(i % 20));
        wr(7'h0C);
        wait_idle(w);
        check("clear_busy_cycles_half", 7'(w >> 1), 7'd64);
        check("clear_busy_cycles_lsb", 7'(w & 1), 7'd0);
        dump(0, 127);
        wr(7'h21);
        rd(0);

        // Randomized traffic against the model.
        repeat (300) wr(rand_code());
        wait_idle(w);
        dump(0, 127);

        // Reset in the middle of a scroll.
        do_reset();
        wr(7'h4D);
        repeat (3) wr(7'h0D);
        wr(7'h51);
        wr(7'h0D);
        rd_addr = 7'd96;
        repeat (50) @(negedge clk);
        check("busy_mid_scroll", 7'(busy), 7'h01);
        do_reset();
        dump(0, 127);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
